// File: rtl/serial_mag_comparator.sv
// Walks two WIDTH-bit operands through an external 2-bit comparator, MSB digit first, early exit on first unequal digit.
// Latency: 2 cycles (first digit decides) up to WIDTH/2+1 cycles (all digits equal), start edge to done.
// No backpressure: start is taken only in IDLE and ignored while busy; results hold until the next accepted start.
module serial_mag_comparator #(
  parameter int WIDTH = 8  // even, >= 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [1:0]       o_dig_a,
  output logic [1:0]       o_dig_b,
  input  logic             i_g_in,
  input  logic             i_e_in,
  input  logic             i_s_in,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_gt,
  output logic             o_eq,
  output logic             o_lt
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic            r_gt;
  logic            r_eq;
  logic            r_lt;

  logic w_accept;
  logic w_dig_eq;
  logic w_last;
  logic w_finish;

  // A digit with no flag set is treated as equal so a broken comparator
  // still lets the walk run to the last digit instead of stalling.
  assign w_accept = (r_state == IDLE) && i_start;
  assign w_dig_eq = i_e_in || !(i_g_in || i_s_in);
  assign w_last   = (r_cnt == '0);
  assign w_finish = (r_state == RUN) && (i_g_in || i_s_in || (w_dig_eq && w_last));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: leave RUN on the first deciding digit or after the last digit
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start)  w_state_nxt = RUN;
      RUN:     if (w_finish) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic: digits go straight from the shift registers to the comparator
  always_comb begin
    o_busy  = (r_state == RUN);
    o_dig_a = 2'b00;
    o_dig_b = 2'b00;
    if (r_state == RUN) begin
      o_dig_a = r_sa[WIDTH-1 -: 2];
      o_dig_b = r_sb[WIDTH-1 -: 2];
    end
  end

  // Datapath: operand shifting, digit count and the sticky word-level result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_gt   <= 1'b0;
      r_eq   <= 1'b0;
      r_lt   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_sa  <= i_a;
        r_sb  <= i_b;
        r_cnt <= CW'(DIGITS - 1);
        r_gt  <= 1'b0;
        r_eq  <= 1'b0;
        r_lt  <= 1'b0;
      end else if (r_state == RUN) begin
        if (i_g_in) begin
          r_gt   <= 1'b1;
          r_done <= 1'b1;
        end else if (i_s_in) begin
          r_lt   <= 1'b1;
          r_done <= 1'b1;
        end else if (w_dig_eq && w_last) begin
          r_eq   <= 1'b1;
          r_done <= 1'b1;
        end else begin
          r_sa  <= r_sa << 2;
          r_sb  <= r_sb << 2;
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_gt   = r_gt;
  assign o_eq   = r_eq;
  assign o_lt   = r_lt;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: an 8-bit instance checked every cycle against
// an arithmetic model, a 2-bit instance checked with literals, plus directed literal checks.
module tb_serial_mag_comparator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start2, illegal;
  logic [7:0] a, b;
  logic [1:0] a2, b2;

  logic [1:0] dig_a, dig_b;
  logic       g_in, e_in, s_in;
  logic       busy, done, gt, eq, lt;

  logic [1:0] dig2_a, dig2_b;
  logic       g2, e2, s2;
  logic       busy2, done2, gt2, eq2, lt2;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Ideal 2-bit comparators; 'illegal' silences all flags of the 8-bit one
  assign g_in = !illegal && (dig_a > dig_b);
  assign e_in = !illegal && (dig_a == dig_b);
  assign s_in = !illegal && (dig_a < dig_b);
  assign g2   = (dig2_a > dig2_b);
  assign e2   = (dig2_a == dig2_b);
  assign s2   = (dig2_a < dig2_b);

  serial_mag_comparator #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b),
    .o_dig_a(dig_a), .o_dig_b(dig_b),
    .i_g_in(g_in), .i_e_in(e_in), .i_s_in(s_in),
    .o_busy(busy), .o_done(done), .o_gt(gt), .o_eq(eq), .o_lt(lt)
  );

  serial_mag_comparator #(.WIDTH(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_a(a2), .i_b(b2),
    .o_dig_a(dig2_a), .o_dig_b(dig2_b),
    .i_g_in(g2), .i_e_in(e2), .i_s_in(s2),
    .o_busy(busy2), .o_done(done2), .o_gt(gt2), .o_eq(eq2), .o_lt(lt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the 8-bit instance ----------------
  // Number of digits examined: position of first differing 2-bit digit (1-based), or 4.
  function automatic int digits_used(input logic [7:0] x, input logic [7:0] y);
    for (int i = 0; i < 4; i++) begin
      if (x[7-2*i -: 2] != y[7-2*i -: 2]) return i + 1;
    end
    return 4;
  endfunction

  logic [7:0] m_a, m_b;
  bit         m_busy = 0, m_done = 0, m_gt = 0, m_eq = 0, m_lt = 0, m_ill = 0;
  int         m_idx = 0, m_ndig = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_gt = 0; m_eq = 0; m_lt = 0; m_idx = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_a = a; m_b = b; m_ill = illegal;
          m_ndig = illegal ? 4 : digits_used(a, b);
          m_busy = 1; m_idx = 0;
          m_gt = 0; m_eq = 0; m_lt = 0;
        end
      end else begin
        m_idx++;
        if (m_idx == m_ndig) begin
          m_busy = 0; m_done = 1;
          if (m_ill) m_eq = 1;
          else begin
            m_gt = (m_a > m_b); m_eq = (m_a == m_b); m_lt = (m_a < m_b);
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy", {31'b0, busy}, {31'b0, m_busy});
      chk("m_done", {31'b0, done}, {31'b0, m_done});
      chk("m_res",  {29'b0, gt, eq, lt}, {29'b0, m_gt, m_eq, m_lt});
      chk("m_dig_a", {30'b0, dig_a}, m_busy ? {30'b0, m_a[7-2*m_idx -: 2]} : 32'd0);
      chk("m_dig_b", {30'b0, dig_b}, m_busy ? {30'b0, m_b[7-2*m_idx -: 2]} : 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input logic [7:0] va, input logic [7:0] vb);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 1;
    while (!done && n < maxc) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  int seq_a[4] = '{2, 2, 1, 1};
  int seq_b[4] = '{2, 2, 1, 1};
  logic [7:0] tv_a[4] = '{8'h80, 8'h3C, 8'h00, 8'h5A};
  logic [7:0] tv_b[4] = '{8'h7F, 8'h3D, 8'h00, 8'h5E};
  int         tv_n[4] = '{2, 5, 5, 4};
  logic [2:0] tv_r[4] = '{3'b100, 3'b001, 3'b010, 3'b001};

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; illegal = 1'b0;
    a = '0; b = '0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_res",  {29'b0, gt, eq, lt}, 0);
    chk("rst_dig",  {28'b0, dig_a, dig_b}, 0);
    rst = 1'b0;
    @(negedge clk);

    // All digits equal: walks all four, digit sequence 2,2,1,1
    do_start(8'hA5, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      chk("a5_busy",  {31'b0, busy}, 1);
      chk("a5_dig_a", {30'b0, dig_a}, seq_a[i]);
      chk("a5_dig_b", {30'b0, dig_b}, seq_b[i]);
      @(negedge clk);
    end
    chk("a5_done", {31'b0, done}, 1);
    chk("a5_busy_off", {31'b0, busy}, 0);
    chk("a5_res", {29'b0, gt, eq, lt}, 3'b010);
    @(negedge clk);

    // First digit decides
    do_start(8'hC0, 8'h40);
    wait_done(20, n);
    chk("c0_lat", n, 2);
    chk("c0_res", {29'b0, gt, eq, lt}, 3'b100);
    @(negedge clk);

    // Last digit decides; a start mid-run is ignored; restart in done cycle
    do_start(8'h12, 8'h13);
    chk("12_res_clear", {29'b0, gt, eq, lt}, 0);
    @(negedge clk);
    a = 8'h00; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("12_no_gt_eq", {30'b0, gt, eq}, 0);
    @(negedge clk);
    chk("12_done", {31'b0, done}, 1);
    chk("12_res", {29'b0, gt, eq, lt}, 3'b001);
    do_start(8'hFF, 8'h00);
    chk("ff_cleared", {29'b0, gt, eq, lt}, 0);
    @(negedge clk);
    chk("ff_done", {31'b0, done}, 1);
    chk("ff_res", {29'b0, gt, eq, lt}, 3'b100);
    @(negedge clk);

    // Reset mid-run abandons the compare
    do_start(8'hA5, 8'hA5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out", {27'b0, busy, done, gt, eq, lt}, 0);
    repeat (5) begin
      @(negedge clk);
      chk("mid_rst_nodone", {31'b0, done}, 0);
    end
    do_start(8'hC0, 8'h40);
    wait_done(20, n);
    chk("post_rst_lat", n, 2);
    chk("post_rst_res", {29'b0, gt, eq, lt}, 3'b100);
    @(negedge clk);

    // Directed table, model also checking every cycle
    for (int t = 0; t < 4; t++) begin
      do_start(tv_a[t], tv_b[t]);
      wait_done(20, n);
      chk("tbl_lat", n, tv_n[t]);
      chk("tbl_res", {29'b0, gt, eq, lt}, {29'b0, tv_r[t]});
      @(negedge clk);
    end

    // Comparator asserting no flag: runs the full length and reports equal
    illegal = 1'b1;
    do_start(8'hC0, 8'h40);
    wait_done(20, n);
    chk("ill_lat", n, 5);
    chk("ill_res", {29'b0, gt, eq, lt}, 3'b010);
    @(negedge clk);
    illegal = 1'b0;

    // Single-digit instance
    a2 = 2'b01; b2 = 2'b01; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("w2_busy", {31'b0, busy2}, 1);
    chk("w2_dig", {30'b0, dig2_a}, 1);
    @(negedge clk);
    chk("w2_done", {31'b0, done2}, 1);
    chk("w2_res", {29'b0, gt2, eq2, lt2}, 3'b010);
    a2 = 2'b10; b2 = 2'b01; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    chk("w2_gt_done", {31'b0, done2}, 1);
    chk("w2_gt_res", {29'b0, gt2, eq2, lt2}, 3'b100);
    @(negedge clk);
    chk("w2_done_pulse", {31'b0, done2}, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
